// File: rtl/unified_mem_arbiter_pkg.sv
// mem_arb_pkg: shared types for the unified memory arbiter.
//   arb_state_t : arbiter FSM state encoding
//   grant_t     : which core port owns the memory bus
//   pick_grant  : grant decision used in IDLE
package mem_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    I_BUSY = 3'd1,
    D_BUSY = 3'd2,
    I_ACK  = 3'd3,
    D_ACK  = 3'd4
  } arb_state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // D wins on its own or on a tie, unless it won the previous tie-capable
  // grant; the alternation keeps either side from being starved.
  function automatic grant_t pick_grant(input logic req_i, input logic req_d,
                                        input grant_t last_grant);
    if (req_d && (!req_i || last_grant != GRANT_D)) return GRANT_D;
    return GRANT_I;
  endfunction

endpackage

// File: rtl/unified_mem_arbiter_if.sv
// unified_mem_arbiter_if: every signal between the arbiter, the core's
// I-fetch / D-memory ports and the external single-port memory.
//   I_*   : instruction fetch request / ack / read data
//   D_*   : data load/store request / ack / read data
//   Mem_* : external memory bus
//   Bus_Error : sticky watchdog error flag
// Modports: slave = the arbiter's view, master = the surrounding system.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int BE_W = DATA_W / 8;

  logic              I_ReadEnable;
  logic [ADDR_W-1:0] I_Address;
  logic              I_Ack;
  logic [DATA_W-1:0] I_ReadData;

  logic              D_ReadEnable;
  logic              D_WriteEnable;
  logic [ADDR_W-1:0] D_Address;
  logic [DATA_W-1:0] D_WriteData;
  logic [BE_W-1:0]   D_ByteEnable;
  logic              D_Ack;
  logic [DATA_W-1:0] D_ReadData;

  logic              Mem_Req;
  logic              Mem_Write;
  logic [ADDR_W-1:0] Mem_Address;
  logic [DATA_W-1:0] Mem_WriteData;
  logic [BE_W-1:0]   Mem_ByteEnable;
  logic              Mem_Ack;
  logic [DATA_W-1:0] Mem_ReadData;

  logic              Bus_Error;

  modport slave (
    input  I_ReadEnable, I_Address,
    output I_Ack, I_ReadData,
    input  D_ReadEnable, D_WriteEnable, D_Address, D_WriteData, D_ByteEnable,
    output D_Ack, D_ReadData,
    output Mem_Req, Mem_Write, Mem_Address, Mem_WriteData, Mem_ByteEnable,
    input  Mem_Ack, Mem_ReadData,
    output Bus_Error
  );

  modport master (
    output I_ReadEnable, I_Address,
    input  I_Ack, I_ReadData,
    output D_ReadEnable, D_WriteEnable, D_Address, D_WriteData, D_ByteEnable,
    input  D_Ack, D_ReadData,
    input  Mem_Req, Mem_Write, Mem_Address, Mem_WriteData, Mem_ByteEnable,
    output Mem_Ack, Mem_ReadData,
    input  Bus_Error
  );

endinterface

// File: rtl/unified_mem_arbiter_watchdog.sv
// arb_watchdog: per-transfer timeout counter.
//   clk, rst : clock, synchronous active-high reset
//   clear    : zero the count (at grant)
//   enable   : count this cycle (while waiting for the memory)
//   expired  : this is the TIMEOUT_CYCLES-th enabled cycle since clear
// TIMEOUT_CYCLES = 0 disables the watchdog (expired never asserts).
module arb_watchdog #(
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      logic [CNT_W-1:0] cnt;

      // The count holds the number of enabled cycles already completed, so
      // the cycle in which it equals TIMEOUT_CYCLES-1 is the last one allowed.
      assign expired = enable && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt <= '0;
        end else if (clear) begin
          cnt <= '0;
        end else if (enable && !expired) begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port memory bus between the core's
// I-fetch and D-memory ports. Latches the winner's request, holds Mem_Req
// until Mem_Ack (or watchdog expiry), then returns a one-cycle Ack with the
// registered read data to the winning side.
//   CLK, RST : clock, synchronous active-high reset
//   bus      : unified_mem_arbiter_if.slave (core ports, memory bus, Bus_Error)
//
// state  | meaning
// IDLE   | no transfer; grant on any request
// I_BUSY | fetch on the bus, waiting for Mem_Ack
// D_BUSY | load/store on the bus, waiting for Mem_Ack
// I_ACK  | I_Ack pulse; no new grant this cycle
// D_ACK  | D_Ack pulse; no new grant this cycle
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input logic                 CLK,
  input logic                 RST,
  unified_mem_arbiter_if.slave bus
);

  localparam int BE_W = DATA_W / 8;

  arb_state_t state_q, state_d;
  grant_t     last_grant_q;
  grant_t     grant_sel;
  logic       req_i, req_d, grant_now;
  logic       wd_clear, wd_en, wd_expired;

  logic              mem_req_q, mem_write_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [BE_W-1:0]   mem_be_q;
  logic              i_ack_q, d_ack_q;
  logic [DATA_W-1:0] i_rdata_q, d_rdata_q;
  logic              bus_error_q;

  assign req_i     = bus.I_ReadEnable;
  assign req_d     = bus.D_ReadEnable | bus.D_WriteEnable;
  assign grant_sel = pick_grant(req_i, req_d, last_grant_q);
  assign grant_now = (state_q == IDLE) && (req_i || req_d);

  always_comb begin
    state_d  = state_q;
    wd_clear = 1'b0;
    wd_en    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_now) begin
          wd_clear = 1'b1;
          state_d  = (grant_sel == GRANT_D) ? D_BUSY : I_BUSY;
        end
      end
      I_BUSY: begin
        wd_en = 1'b1;
        if (bus.Mem_Ack || wd_expired) state_d = I_ACK;
      end
      D_BUSY: begin
        wd_en = 1'b1;
        if (bus.Mem_Ack || wd_expired) state_d = D_ACK;
      end
      I_ACK:   state_d = IDLE;
      D_ACK:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clk     (CLK),
    .rst     (RST),
    .clear   (wd_clear),
    .enable  (wd_en),
    .expired (wd_expired)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      mem_req_q    <= 1'b0;
      mem_write_q  <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      i_ack_q      <= 1'b0;
      d_ack_q      <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      bus_error_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_req_q <= (state_d == I_BUSY) || (state_d == D_BUSY);
      i_ack_q   <= (state_d == I_ACK);
      d_ack_q   <= (state_d == D_ACK);

      if (grant_now) begin
        last_grant_q <= grant_sel;
        if (grant_sel == GRANT_D) begin
          // Read and write both high is a store.
          mem_write_q <= bus.D_WriteEnable;
          mem_addr_q  <= bus.D_Address;
          mem_wdata_q <= bus.D_WriteData;
          mem_be_q    <= bus.D_WriteEnable ? bus.D_ByteEnable : '1;
        end else begin
          mem_write_q <= 1'b0;
          mem_addr_q  <= bus.I_Address;
          mem_wdata_q <= '0;
          mem_be_q    <= '1;
        end
      end

      // A real Mem_Ack wins over a watchdog expiry in the same cycle.
      if (state_q == I_BUSY) begin
        if (bus.Mem_Ack)     i_rdata_q <= bus.Mem_ReadData;
        else if (wd_expired) i_rdata_q <= '0;
      end
      if (state_q == D_BUSY) begin
        if (bus.Mem_Ack)     d_rdata_q <= bus.Mem_ReadData;
        else if (wd_expired) d_rdata_q <= '0;
      end

      if (wd_expired && !bus.Mem_Ack) bus_error_q <= 1'b1;
    end
  end

  assign bus.I_Ack          = i_ack_q;
  assign bus.I_ReadData     = i_rdata_q;
  assign bus.D_Ack          = d_ack_q;
  assign bus.D_ReadData     = d_rdata_q;
  assign bus.Mem_Req        = mem_req_q;
  assign bus.Mem_Write      = mem_write_q;
  assign bus.Mem_Address    = mem_addr_q;
  assign bus.Mem_WriteData  = mem_wdata_q;
  assign bus.Mem_ByteEnable = mem_be_q;
  assign bus.Bus_Error      = bus_error_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter (TIMEOUT_CYCLES = 8).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_unified_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  unified_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus.slave)
  );

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.Mem_Req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", bus.Mem_Req); end
    checks++; if (bus.Mem_Address !== 32'h0) begin errors++; $display("FAIL rst_addr: got %h want 0", bus.Mem_Address); end
    checks++; if (bus.Mem_ByteEnable !== 4'h0) begin errors++; $display("FAIL rst_be: got %h want 0", bus.Mem_ByteEnable); end
    checks++; if ({bus.I_Ack, bus.D_Ack, bus.Bus_Error, bus.Mem_Write} !== 4'b0) begin errors++; $display("FAIL rst_flags: got %b want 0000", {bus.I_Ack, bus.D_Ack, bus.Bus_Error, bus.Mem_Write}); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.Mem_Req !== 1'b0) begin errors++; $display("FAIL rst_idle_req: got %b want 0", bus.Mem_Req); end
  endtask

  task automatic test_single_fetch();
    bus.I_ReadEnable = 1'b1; bus.I_Address = 32'h40;
    @(negedge clk);
    checks++; if (bus.Mem_Req !== 1'b1) begin errors++; $display("FAIL t1_req: got %b want 1", bus.Mem_Req); end
    checks++; if (bus.Mem_Write !== 1'b0) begin errors++; $display("FAIL t1_write: got %b want 0", bus.Mem_Write); end
    checks++; if (bus.Mem_ByteEnable !== 4'hF) begin errors++; $display("FAIL t1_be: got %h want f", bus.Mem_ByteEnable); end
    checks++; if (bus.Mem_Address !== 32'h40) begin errors++; $display("FAIL t1_addr: got %h want 40", bus.Mem_Address); end
    @(negedge clk);
    checks++; if (bus.I_Ack !== 1'b0) begin errors++; $display("FAIL t1_early_ack: got %b want 0", bus.I_Ack); end
    bus.Mem_Ack = 1'b1; bus.Mem_ReadData = 32'h2408_0005;
    @(negedge clk);
    bus.Mem_Ack = 1'b0; bus.Mem_ReadData = 32'h0;
    checks++; if (bus.I_Ack !== 1'b1) begin errors++; $display("FAIL t1_ack: got %b want 1", bus.I_Ack); end
    checks++; if (bus.I_ReadData !== 32'h2408_0005) begin errors++; $display("FAIL t1_rdata: got %h want 24080005", bus.I_ReadData); end
    checks++; if (bus.Mem_Req !== 1'b0) begin errors++; $display("FAIL t1_req_drop: got %b want 0", bus.Mem_Req); end
    checks++; if (bus.D_Ack !== 1'b0) begin errors++; $display("FAIL t1_dack: got %b want 0", bus.D_Ack); end
    // Enable still high through the ACK cycle: must not re-trigger.
    @(negedge clk);
    checks++; if (bus.I_Ack !== 1'b0) begin errors++; $display("FAIL t1_ack_once: got %b want 0", bus.I_Ack); end
    checks++; if (bus.Mem_Req !== 1'b0) begin errors++; $display("FAIL t1_no_retrigger: got %b want 0", bus.Mem_Req); end
    bus.I_ReadEnable = 1'b0;
    @(negedge clk);
    checks++; if (bus.Mem_Req !== 1'b0) begin errors++; $display("FAIL t1_idle: got %b want 0", bus.Mem_Req); end
  endtask

  task automatic test_simultaneous();
    bus.I_ReadEnable = 1'b1; bus.I_Address = 32'h80;
    bus.D_WriteEnable = 1'b1; bus.D_Address = 32'h100;
    bus.D_WriteData = 32'hDEAD_BEEF; bus.D_ByteEnable = 4'b0011;
    @(negedge clk);
    checks++; if (bus.Mem_Write !== 1'b1) begin errors++; $display("FAIL t2_d_first: got %b want 1", bus.Mem_Write); end
    checks++; if (bus.Mem_Address !== 32'h100) begin errors++; $display("FAIL t2_d_addr: got %h want 100", bus.Mem_Address); end
    checks++; if (bus.Mem_ByteEnable !== 4'b0011) begin errors++; $display("FAIL t2_d_be: got %b want 0011", bus.Mem_ByteEnable); end
    checks++; if (bus.Mem_WriteData !== 32'hDEAD_BEEF) begin errors++; $display("FAIL t2_d_wdata: got %h want deadbeef", bus.Mem_WriteData); end
    bus.Mem_Ack = 1'b1;
    @(negedge clk);
    bus.Mem_Ack = 1'b0;
    checks++; if (bus.D_Ack !== 1'b1) begin errors++; $display("FAIL t2_dack: got %b want 1", bus.D_Ack); end
    checks++; if (bus.I_Ack !== 1'b0) begin errors++; $display("FAIL t2_iack_early: got %b want 0", bus.I_Ack); end
    bus.D_WriteEnable = 1'b0;
    @(negedge clk);
    checks++; if (bus.Mem_Req !== 1'b0) begin errors++; $display("FAIL t2_gap: got %b want 0", bus.Mem_Req); end
    @(negedge clk);
    checks++; if (bus.Mem_Req !== 1'b1) begin errors++; $display("FAIL t2_i_req: got %b want 1", bus.Mem_Req); end
    checks++; if (bus.Mem_Address !== 32'h80) begin errors++; $display("FAIL t2_i_addr: got %h want 80", bus.Mem_Address); end
    checks++; if ({bus.Mem_Write, bus.Mem_ByteEnable} !== 5'b0_1111) begin errors++; $display("FAIL t2_i_wr_be: got %b want 01111", {bus.Mem_Write, bus.Mem_ByteEnable}); end
    bus.Mem_Ack = 1'b1; bus.Mem_ReadData = 32'h1111_2222;
    @(negedge clk);
    bus.Mem_Ack = 1'b0; bus.Mem_ReadData = 32'h0;
    checks++; if (bus.I_Ack !== 1'b1) begin errors++; $display("FAIL t2_iack: got %b want 1", bus.I_Ack); end
    checks++; if (bus.I_ReadData !== 32'h1111_2222) begin errors++; $display("FAIL t2_irdata: got %h want 11112222", bus.I_ReadData); end
    bus.I_ReadEnable = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    bit exp_d;
    bus.I_ReadEnable = 1'b1; bus.I_Address = 32'h44;
    bus.D_WriteEnable = 1'b1; bus.D_Address = 32'h140;
    bus.D_WriteData = 32'h0BAD_F00D; bus.D_ByteEnable = 4'hF;
    for (int k = 0; k < 6; k++) begin
      exp_d = (k % 2 == 0);
      for (int w = 0; w < 10 && bus.Mem_Req !== 1'b1; w++) @(negedge clk);
      checks++; if (bus.Mem_Req !== 1'b1) begin errors++; $display("FAIL t3_wait[%0d]: got %b want 1", k, bus.Mem_Req); end
      checks++; if (bus.Mem_Write !== exp_d) begin errors++; $display("FAIL t3_grant[%0d]: got write=%b want %b", k, bus.Mem_Write, exp_d); end
      bus.Mem_Ack = 1'b1; bus.Mem_ReadData = 32'h100 + k;
      @(negedge clk);
      bus.Mem_Ack = 1'b0;
      checks++; if ({bus.D_Ack, bus.I_Ack} !== {exp_d, !exp_d}) begin errors++; $display("FAIL t3_ack[%0d]: got d/i=%b%b want %b%b", k, bus.D_Ack, bus.I_Ack, exp_d, !exp_d); end
    end
    bus.I_ReadEnable = 1'b0; bus.D_WriteEnable = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.Mem_Req !== 1'b0) begin errors++; $display("FAIL t3_done: got %b want 0", bus.Mem_Req); end
  endtask

  task automatic test_latch_and_stray();
    bus.D_ReadEnable = 1'b1; bus.D_Address = 32'h200; bus.D_ByteEnable = 4'b0001;
    @(negedge clk);
    checks++; if (bus.Mem_Address !== 32'h200) begin errors++; $display("FAIL t4_addr: got %h want 200", bus.Mem_Address); end
    checks++; if ({bus.Mem_Write, bus.Mem_ByteEnable} !== 5'b0_1111) begin errors++; $display("FAIL t4_load_wr_be: got %b want 01111", {bus.Mem_Write, bus.Mem_ByteEnable}); end
    bus.D_Address = 32'h300;
    @(negedge clk);
    checks++; if (bus.Mem_Address !== 32'h200) begin errors++; $display("FAIL t4_addr_held: got %h want 200", bus.Mem_Address); end
    bus.Mem_Ack = 1'b1; bus.Mem_ReadData = 32'hCAFE_F00D;
    @(negedge clk);
    bus.Mem_Ack = 1'b0;
    checks++; if (bus.D_Ack !== 1'b1) begin errors++; $display("FAIL t4_dack: got %b want 1", bus.D_Ack); end
    checks++; if (bus.D_ReadData !== 32'hCAFE_F00D) begin errors++; $display("FAIL t4_drdata: got %h want cafef00d", bus.D_ReadData); end
    bus.D_ReadEnable = 1'b0;
    @(negedge clk);
    bus.Mem_Ack = 1'b1; bus.Mem_ReadData = 32'h5555_5555;
    @(negedge clk);
    bus.Mem_Ack = 1'b0; bus.Mem_ReadData = 32'h0;
    checks++; if ({bus.D_Ack, bus.I_Ack, bus.Mem_Req} !== 3'b000) begin errors++; $display("FAIL t4_stray: got d/i/req=%b want 000", {bus.D_Ack, bus.I_Ack, bus.Mem_Req}); end
    checks++; if (bus.D_ReadData !== 32'hCAFE_F00D) begin errors++; $display("FAIL t4_hold: got %h want cafef00d", bus.D_ReadData); end
    @(negedge clk);
    checks++; if ({bus.D_Ack, bus.I_Ack} !== 2'b00) begin errors++; $display("FAIL t4_stray2: got %b want 00", {bus.D_Ack, bus.I_Ack}); end
  endtask

  task automatic test_timeout();
    bus.I_ReadEnable = 1'b1; bus.I_Address = 32'h500;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++; if ({bus.Mem_Req, bus.Bus_Error} !== 2'b10) begin errors++; $display("FAIL t5_busy[%0d]: got req/err=%b want 10", i, {bus.Mem_Req, bus.Bus_Error}); end
    end
    @(negedge clk);
    checks++; if (bus.I_Ack !== 1'b1) begin errors++; $display("FAIL t5_ack: got %b want 1", bus.I_Ack); end
    checks++; if (bus.I_ReadData !== 32'h0) begin errors++; $display("FAIL t5_data: got %h want 0", bus.I_ReadData); end
    checks++; if (bus.Bus_Error !== 1'b1) begin errors++; $display("FAIL t5_err: got %b want 1", bus.Bus_Error); end
    checks++; if (bus.Mem_Req !== 1'b0) begin errors++; $display("FAIL t5_req_drop: got %b want 0", bus.Mem_Req); end
    bus.I_ReadEnable = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if ({bus.I_Ack, bus.Bus_Error} !== 2'b01) begin errors++; $display("FAIL t5_sticky: got ack/err=%b want 01", {bus.I_Ack, bus.Bus_Error}); end
  endtask

  task automatic test_reset_mid_transfer();
    bus.D_WriteEnable = 1'b1; bus.D_Address = 32'h600; bus.D_WriteData = 32'h0; bus.D_ByteEnable = 4'hF;
    @(negedge clk);
    checks++; if (bus.Mem_Req !== 1'b1) begin errors++; $display("FAIL t6_busy: got %b want 1", bus.Mem_Req); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if ({bus.Mem_Req, bus.D_Ack, bus.Bus_Error} !== 3'b000) begin errors++; $display("FAIL t6_reset: got req/dack/err=%b want 000", {bus.Mem_Req, bus.D_Ack, bus.Bus_Error}); end
    bus.D_WriteEnable = 1'b0;
    @(negedge clk);
    checks++; if ({bus.Mem_Req, bus.D_Ack} !== 2'b00) begin errors++; $display("FAIL t6_abandon: got req/dack=%b want 00", {bus.Mem_Req, bus.D_Ack}); end
    bus.I_ReadEnable = 1'b1; bus.I_Address = 32'h700;
    @(negedge clk);
    checks++; if ({bus.Mem_Req, bus.Mem_Write} !== 2'b10) begin errors++; $display("FAIL t6_i_req: got req/wr=%b want 10", {bus.Mem_Req, bus.Mem_Write}); end
    checks++; if (bus.Mem_Address !== 32'h700) begin errors++; $display("FAIL t6_i_addr: got %h want 700", bus.Mem_Address); end
    bus.Mem_Ack = 1'b1; bus.Mem_ReadData = 32'h1234_5678;
    @(negedge clk);
    bus.Mem_Ack = 1'b0;
    checks++; if (bus.I_Ack !== 1'b1) begin errors++; $display("FAIL t6_iack: got %b want 1", bus.I_Ack); end
    checks++; if (bus.I_ReadData !== 32'h1234_5678) begin errors++; $display("FAIL t6_irdata: got %h want 12345678", bus.I_ReadData); end
    bus.I_ReadEnable = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.I_ReadEnable = 1'b0; bus.I_Address = '0;
    bus.D_ReadEnable = 1'b0; bus.D_WriteEnable = 1'b0; bus.D_Address = '0;
    bus.D_WriteData = '0; bus.D_ByteEnable = '0;
    bus.Mem_Ack = 1'b0; bus.Mem_ReadData = '0;
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_back_to_back();
    test_latch_and_stray();
    test_timeout();
    test_reset_mid_transfer();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation time %0t exceeded limit", $time);
    $fatal(1);
  end

endmodule
